// File: rtl/gtxe2_chnl_rx_chbond_pkg.sv
// Shared constants, state encoding and width helper for the GTXE2 RX
// channel-bonding (deskew) stage.
package gtxe2_chnl_rx_chbond_pkg;

  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    ALIGNED = 2'd2
  } bond_state_e;

  // Never returns less than 1 so a degenerate MAX_SKEW still gives a legal vector.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_rx_chbond_lane.sv
// One bonded lane: delay line of MAX_SKEW+1 taps, tap select, bond-character
// detection on both the raw input and the selected tap, and the output register.
module gtxe2_chnl_rx_chbond_lane
  import gtxe2_chnl_rx_chbond_pkg::*;
#(
  parameter int         BYTES     = 2,
  parameter int         MAX_SKEW  = 8,
  parameter logic [7:0] BOND_CHAR = K28_3,
  parameter int         SW        = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BYTES*8-1:0]   data_i,
  input  logic [BYTES-1:0]     isk_i,
  input  logic [SW-1:0]        delay_i,
  output logic [BYTES*8-1:0]   data_o,
  output logic [BYTES-1:0]     isk_o,
  output logic                 detRaw_o,
  output logic                 detTap_o
);

  localparam int LW = BYTES * 8;
  localparam int WW = LW + BYTES;

  logic [WW-1:0] inWord;
  logic [WW-1:0] tapWord;
  logic [WW-1:0] outWord_q;
  logic [WW-1:0] hist_q [MAX_SKEW];

  assign inWord = {isk_i, data_i};

  // hist_q[k] holds the word sampled k+1 edges ago, i.e. tap(k+1).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < MAX_SKEW; k++) hist_q[k] <= '0;
      outWord_q <= '0;
    end else begin
      hist_q[0] <= inWord;
      for (int k = 1; k < MAX_SKEW; k++) hist_q[k] <= hist_q[k-1];
      outWord_q <= tapWord;
    end
  end

  always_comb begin
    tapWord = inWord;
    for (int k = 1; k <= MAX_SKEW; k++) begin
      if (int'(delay_i) == k) tapWord = hist_q[k-1];
    end
  end

  // An unknown K flag or byte leaves the if condition false, so x never detects.
  always_comb begin
    detRaw_o = 1'b0;
    detTap_o = 1'b0;
    if (isk_i[0] && (data_i[7:0] == BOND_CHAR)) detRaw_o = 1'b1;
    if (tapWord[LW] && (tapWord[7:0] == BOND_CHAR)) detTap_o = 1'b1;
  end

  assign data_o = outWord_q[LW-1:0];
  assign isk_o  = outWord_q[WW-1:LW];

endmodule

// File: rtl/gtxe2_chnl_rx_chbond.sv
// Multi-lane RX channel bonding: hunts for the bond character on every lane,
// measures arrival skew and delays early lanes so all lanes leave word-aligned.
module gtxe2_chnl_rx_chbond
  import gtxe2_chnl_rx_chbond_pkg::*;
#(
  parameter int         LANES     = 4,
  parameter int         BYTES     = 2,
  parameter int         MAX_SKEW  = 8,
  parameter logic [7:0] BOND_CHAR = K28_3,
  localparam int        SW        = clog2(MAX_SKEW + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bond_en,
  input  logic [LANES*BYTES*8-1:0] in_data,
  input  logic [LANES*BYTES-1:0]   in_isk,
  output logic [LANES*BYTES*8-1:0] out_data,
  output logic [LANES*BYTES-1:0]   out_isk,
  output logic                     bonded,
  output logic                     bond_err,
  output logic [LANES*SW-1:0]      lane_delay
);

  localparam int             LW        = BYTES * 8;
  localparam logic [SW-1:0]  MAX_CNT   = SW'(MAX_SKEW);
  localparam logic [LANES-1:0] ALL_LANES = '1;

  bond_state_e      state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    arrival_q [LANES];
  logic [SW-1:0]    arrival_d [LANES];
  logic [SW-1:0]    delay_q [LANES];
  logic [SW-1:0]    delay_d [LANES];
  logic [LANES-1:0] seen_q, seen_d;
  logic             bonded_q, bonded_d;
  logic             bondErr_q, bondErr_d;
  logic [LANES-1:0] detRaw, detTap, newSeen;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gtxe2_chnl_rx_chbond_lane #(
      .BYTES     (BYTES),
      .MAX_SKEW  (MAX_SKEW),
      .BOND_CHAR (BOND_CHAR),
      .SW        (SW)
    ) u_lane (
      .clk_i    (clk),
      .rst_i    (rst),
      .data_i   (in_data[i*LW +: LW]),
      .isk_i    (in_isk[i*BYTES +: BYTES]),
      .delay_i  (delay_q[i]),
      .data_o   (out_data[i*LW +: LW]),
      .isk_o    (out_isk[i*BYTES +: BYTES]),
      .detRaw_o (detRaw[i]),
      .detTap_o (detTap[i])
    );
    assign lane_delay[i*SW +: SW] = delay_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      arrival_q <= '{default: '0};
      delay_q   <= '{default: '0};
      seen_q    <= '0;
      bonded_q  <= 1'b0;
      bondErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arrival_q <= arrival_d;
      delay_q   <= delay_d;
      seen_q    <= seen_d;
      bonded_q  <= bonded_d;
      bondErr_q <= bondErr_d;
    end
  end

  // Hunting uses raw-input detection; supervision in ALIGNED uses the delayed taps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arrival_d = arrival_q;
    delay_d   = delay_q;
    seen_d    = seen_q;
    bonded_d  = bonded_q;
    bondErr_d = 1'b0;
    newSeen   = seen_q | detRaw;

    if (!bond_en) begin
      state_d  = IDLE;
      bonded_d = 1'b0;
      delay_d  = '{default: '0};
      seen_d   = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          bonded_d = 1'b0;
          delay_d  = '{default: '0};
          seen_d   = '0;
          cnt_d    = '0;
          state_d  = HUNT;
        end
        HUNT: begin
          for (int i = 0; i < LANES; i++) begin
            if (detRaw[i] && !seen_q[i]) arrival_d[i] = cnt_q;
          end
          seen_d = newSeen;
          if (newSeen == ALL_LANES) begin
            for (int i = 0; i < LANES; i++) delay_d[i] = cnt_q - arrival_d[i];
            bonded_d = 1'b1;
            state_d  = ALIGNED;
            seen_d   = '0;
            cnt_d    = '0;
          end else if ((seen_q != '0) && (cnt_q == MAX_CNT)) begin
            bondErr_d = 1'b1;
            seen_d    = '0;
            cnt_d     = '0;
          end else if ((newSeen != '0) && (cnt_q < MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ALIGNED: begin
          if ((detTap != '0) && (detTap != ALL_LANES)) begin
            bondErr_d = 1'b1;
            bonded_d  = 1'b0;
            state_d   = HUNT;
            seen_d    = '0;
            cnt_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bonded   = bonded_q;
  assign bond_err = bondErr_q;

endmodule

// File: tb/tb_gtxe2_chnl_rx_chbond.sv
// Directed, table-driven bench for the 4-lane / 2-byte / MAX_SKEW=8 bonding stage.
module tb_gtxe2_chnl_rx_chbond;

  localparam int LANES = 4;
  localparam int BYTES = 2;
  localparam int LW    = BYTES * 8;
  localparam int DW    = LANES * LW;
  localparam int KW    = LANES * BYTES;
  localparam int SW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          bond_en;
  logic [DW-1:0] in_data;
  logic [KW-1:0] in_isk;
  logic [DW-1:0] out_data;
  logic [KW-1:0] out_isk;
  logic          bonded;
  logic          bond_err;
  logic [LANES*SW-1:0] lane_delay;

  always #5 clk = ~clk;

  gtxe2_chnl_rx_chbond #(
    .LANES     (LANES),
    .BYTES     (BYTES),
    .MAX_SKEW  (8),
    .BOND_CHAR (8'h7C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bond_en    (bond_en),
    .in_data    (in_data),
    .in_isk     (in_isk),
    .out_data   (out_data),
    .out_isk    (out_isk),
    .bonded     (bonded),
    .bond_err   (bond_err),
    .lane_delay (lane_delay)
  );

  typedef struct {
    logic        bondEn;
    logic [3:0]  mask;
    logic        expBonded;
    logic        expErr;
    logic [15:0] expDelay;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] histData [0:127];
  logic [KW-1:0] histIsk  [0:127];
  int            checks;
  int            failures;

  function automatic void addVec(input logic en, input logic [3:0] mask, input logic b,
                                 input logic e, input logic [15:0] d);
    vec_t v;
    v.bondEn = en; v.mask = mask; v.expBonded = b; v.expErr = e; v.expDelay = d;
    vecs.push_back(v);
  endfunction

  // Lanes in mask send 0x7C/K in byte 0; the others send numbered filler.
  task automatic applyStimulus(input logic en, input logic [3:0] mask, input int step);
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        in_data[i*LW +: LW]      = {8'(step), 8'h7C};
        in_isk[i*BYTES +: BYTES] = 2'b01;
      end else begin
        in_data[i*LW +: LW]      = {8'(16 * i + 1), 2'(i), 6'(step)};
        in_isk[i*BYTES +: BYTES] = {step[0], 1'b0};
      end
    end
    bond_en        = en;
    histData[step] = in_data;
    histIsk[step]  = in_isk;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0]   prevDelay;
    logic [DW-1:0] expData;
    logic [KW-1:0] expIsk;
    int            d;
    int            src;

    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bond_en  = 1'b0;
    in_data  = '0;
    in_isk   = '0;

    #12;
    checkOutput("reset bonded", 64'(bonded), 64'd0);
    checkOutput("reset bond_err", 64'(bond_err), 64'd0);
    checkOutput("reset lane_delay", 64'(lane_delay), 64'd0);
    checkOutput("reset out_data", 64'(out_data), 64'd0);
    checkOutput("reset out_isk", 64'(out_isk), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero skew, then a second all-lane bond char while aligned.
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'hF, 1, 0, 16'h0000);
    addVec(1, 4'h0, 1, 0, 16'h0000);
    addVec(1, 4'hF, 1, 0, 16'h0000);
    addVec(1, 4'h0, 1, 0, 16'h0000);
    // Skew 0,2,5,3 on lanes 0..3, repeated once in the aligned state.
    addVec(0, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h1, 0, 0, 16'h0000);
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h2, 0, 0, 16'h0000);
    addVec(1, 4'h8, 0, 0, 16'h0000);
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h4, 1, 0, 16'h2035);
    addVec(1, 4'h0, 1, 0, 16'h2035);
    addVec(1, 4'h1, 1, 0, 16'h2035);
    addVec(1, 4'h0, 1, 0, 16'h2035);
    addVec(1, 4'h2, 1, 0, 16'h2035);
    addVec(1, 4'h8, 1, 0, 16'h2035);
    addVec(1, 4'h0, 1, 0, 16'h2035);
    addVec(1, 4'h4, 1, 0, 16'h2035);
    addVec(1, 4'h0, 1, 0, 16'h2035);
    // bond_en dropped while aligned.
    addVec(0, 4'h0, 0, 0, 16'h0000);
    // Maximum skew of 8 is accepted.
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h7, 0, 0, 16'h0000);
    for (int i = 0; i < 7; i++) addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h8, 1, 0, 16'h0888);
    addVec(1, 4'h0, 1, 0, 16'h0888);
    // Skew of 9 times out, then an aligned pattern bonds.
    addVec(0, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h7, 0, 0, 16'h0000);
    for (int i = 0; i < 7; i++) addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h0, 0, 1, 16'h0000);
    addVec(1, 4'hF, 1, 0, 16'h0000);
    addVec(1, 4'h0, 1, 0, 16'h0000);
    // Lane 2 early by 3, then slips one word later: loss, retained delay, re-bond.
    addVec(0, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h4, 0, 0, 16'h0000);
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'hB, 1, 0, 16'h0300);
    addVec(1, 4'h0, 1, 0, 16'h0300);
    addVec(1, 4'h0, 1, 0, 16'h0300);
    addVec(1, 4'h4, 1, 0, 16'h0300);
    addVec(1, 4'h0, 1, 0, 16'h0300);
    addVec(1, 4'hB, 0, 1, 16'h0300);
    addVec(1, 4'h0, 0, 0, 16'h0300);
    addVec(1, 4'h0, 0, 0, 16'h0300);
    addVec(1, 4'h4, 0, 0, 16'h0300);
    addVec(1, 4'h0, 0, 0, 16'h0300);
    addVec(1, 4'hB, 1, 0, 16'h0200);
    addVec(1, 4'h0, 1, 0, 16'h0200);
    // Duplicate lane-0 detection: first arrival wins; the stray copy then
    // shows up alone in the aligned view and breaks alignment.
    addVec(0, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h0, 0, 0, 16'h0000);
    addVec(1, 4'h1, 0, 0, 16'h0000);
    addVec(1, 4'h1, 0, 0, 16'h0000);
    addVec(1, 4'hE, 1, 0, 16'h0002);
    addVec(1, 4'h0, 0, 1, 16'h0002);
    addVec(1, 4'h1, 0, 0, 16'h0002);

    prevDelay = 16'h0000;
    for (int s = 0; s < vecs.size(); s++) begin
      applyStimulus(vecs[s].bondEn, vecs[s].mask, s);
      checkOutput($sformatf("step%0d bonded", s), 64'(bonded), 64'(vecs[s].expBonded));
      checkOutput($sformatf("step%0d bond_err", s), 64'(bond_err), 64'(vecs[s].expErr));
      checkOutput($sformatf("step%0d lane_delay", s), 64'(lane_delay), 64'(vecs[s].expDelay));
      for (int i = 0; i < LANES; i++) begin
        d   = int'(prevDelay[i*SW +: SW]);
        src = s - d;
        expData[i*LW +: LW]      = (src >= 0) ? histData[src][i*LW +: LW] : '0;
        expIsk[i*BYTES +: BYTES] = (src >= 0) ? histIsk[src][i*BYTES +: BYTES] : '0;
      end
      checkOutput($sformatf("step%0d out_data", s), 64'(out_data), 64'(expData));
      checkOutput($sformatf("step%0d out_isk", s), 64'(out_isk), 64'(expIsk));
      prevDelay = vecs[s].expDelay;
    end

    // Asynchronous reset mid-HUNT with a non-zero retained delay.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst bonded", 64'(bonded), 64'd0);
    checkOutput("async rst bond_err", 64'(bond_err), 64'd0);
    checkOutput("async rst lane_delay", 64'(lane_delay), 64'd0);
    checkOutput("async rst out_data", 64'(out_data), 64'd0);
    checkOutput("async rst out_isk", 64'(out_isk), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // From IDLE a full bond pattern only moves to HUNT.
    applyStimulus(1, 4'hF, 100);
    checkOutput("post-rst idle bonded", 64'(bonded), 64'd0);

    // Bond byte with unknown K flags must not detect.
    for (int i = 0; i < LANES; i++) in_data[i*LW +: LW] = 16'h007C;
    in_isk = 'x;
    @(posedge clk);
    #1;
    checkOutput("x isk bonded", 64'(bonded), 64'd0);
    checkOutput("x isk bond_err", 64'(bond_err), 64'd0);

    applyStimulus(1, 4'hF, 102);
    checkOutput("rebond bonded", 64'(bonded), 64'd1);
    checkOutput("rebond lane_delay", 64'(lane_delay), 64'd0);
    checkOutput("rebond out_data", 64'(out_data), 64'(histData[102]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
